// File: rtl/ec_point_check_pkg.sv
// Shared curve constants (secp256k1: BW_GF, PRIME, COEF_A, COEF_B, GX, GY) plus modular helpers
// and latencies of the shared multiplier/adder used by ec_point_check.
`ifndef EC_DEFINES_VH
`define EC_DEFINES_VH
`define BW_GF  256
`define PRIME  256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
`define COEF_A 256'h0
`define COEF_B 256'h7
`define GX     256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798
`define GY     256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8
`endif

package ec_point_check_pkg;

  localparam int MUL_LAT = 2;
  localparam int ADD_LAT = 1;
  localparam logic [`BW_GF-1:0] PRIME_P = `PRIME;

  function automatic logic [`BW_GF-1:0] mod_mul(input logic [`BW_GF-1:0] a,
                                                input logic [`BW_GF-1:0] b);
    return `BW_GF'(({{`BW_GF{1'b0}}, a} * {{`BW_GF{1'b0}}, b}) % {{`BW_GF{1'b0}}, PRIME_P});
  endfunction

  // Operands are already reduced, so a single conditional subtract suffices.
  function automatic logic [`BW_GF-1:0] mod_add(input logic [`BW_GF-1:0] a,
                                                input logic [`BW_GF-1:0] b);
    logic [`BW_GF:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, PRIME_P}) sum = sum - {1'b0, PRIME_P};
    return sum[`BW_GF-1:0];
  endfunction

endpackage

// File: rtl/ADD_256.sv
// Shared modular adder: res = a+b mod p, valid pulses LAT cycles after an en pulse.
// srst_n is a synchronous active-low reset; a new en overrides any operation in flight.
module ADD_256
  import ec_point_check_pkg::*;
#(
  parameter int LAT = ADD_LAT
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              en,
  input  logic [`BW_GF-1:0] a,
  input  logic [`BW_GF-1:0] b,
  output logic              valid,
  output logic [`BW_GF-1:0] res
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      cnt <= 8'd0;
      res <= '0;
    end else if (en) begin
      cnt <= 8'(LAT);
      res <= mod_add(a, b);
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign valid = (cnt == 8'd1);

endmodule

// File: rtl/Multiplication_256x256.sv
// Shared modular multiplier: res = a*b mod p, valid pulses LAT cycles after a start pulse.
// srst_n is a synchronous active-low reset; a new start overrides any operation in flight.
module Multiplication_256x256
  import ec_point_check_pkg::*;
#(
  parameter int LAT = MUL_LAT
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              start,
  input  logic [`BW_GF-1:0] a,
  input  logic [`BW_GF-1:0] b,
  output logic              valid,
  output logic [`BW_GF-1:0] res
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      cnt <= 8'd0;
      res <= '0;
    end else if (start) begin
      cnt <= 8'(LAT);
      res <= mod_mul(a, b);
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign valid = (cnt == 8'd1);

endmodule

// File: rtl/ec_point_check.sv
// Checks (Px,Py) is in range and on y^2 = x^3 + a*x + b mod p; start ignored while busy.
// Optional ECCHK_INFINITY_EN: (0,0) is reported on_curve as the point at infinity without arithmetic.
module ec_point_check
  import ec_point_check_pkg::*;
#(
  parameter int BW      = `BW_GF,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [BW-1:0] Px,
  input  logic [BW-1:0] Py,
  output logic          busy,
  output logic          done,
  output logic          on_curve,
  output logic          err_range,
  output logic          err_tmo
);

  typedef enum logic [3:0] {
    IDLE, RANGE, MUL_YY, MUL_XX, ADD_A, MUL_X, ADD_B, CMP, DONE
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, state_d;
  logic [BW-1:0] x_q, y_q, t0_q, t1_q;
  logic [CW-1:0] wait_cnt;
  logic          is_mul, is_add, in_arith;
  logic          accept, ld_t0, ld_t1, set_range, set_tmo, set_curve;
  logic          unit_srst_n, mul_start, add_en, mul_vld, add_vld;
  logic [BW-1:0] mul_a, mul_b, mul_res, add_b, add_res;

  assign is_mul   = (state == MUL_YY) || (state == MUL_XX) || (state == MUL_X);
  assign is_add   = (state == ADD_A) || (state == ADD_B);
  assign in_arith = is_mul || is_add;

  // The wait counter doubles as the entry marker for the one-cycle unit start.
  assign mul_start = is_mul && (wait_cnt == '0);
  assign add_en    = is_add && (wait_cnt == '0);

  assign mul_a = (state == MUL_X) ? t1_q : ((state == MUL_XX) ? x_q : y_q);
  assign mul_b = (state == MUL_YY) ? y_q : x_q;
  assign add_b = (state == ADD_A) ? `COEF_A : `COEF_B;

  assign unit_srst_n = ~rst;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  Multiplication_256x256 #(.LAT(MUL_LAT)) u_mul (
    .clk    (clk),
    .srst_n (unit_srst_n),
    .start  (mul_start),
    .a      (mul_a),
    .b      (mul_b),
    .valid  (mul_vld),
    .res    (mul_res)
  );

  ADD_256 #(.LAT(ADD_LAT)) u_add (
    .clk    (clk),
    .srst_n (unit_srst_n),
    .en     (add_en),
    .a      (t1_q),
    .b      (add_b),
    .valid  (add_vld),
    .res    (add_res)
  );

  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    ld_t0     = 1'b0;
    ld_t1     = 1'b0;
    set_range = 1'b0;
    set_tmo   = 1'b0;
    set_curve = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_d = RANGE;
      end
      RANGE: begin
        if (x_q >= PRIME_P || y_q >= PRIME_P) begin
          set_range = 1'b1;
          state_d   = DONE;
        end
`ifdef ECCHK_INFINITY_EN
        else if (x_q == '0 && y_q == '0) begin
          set_curve = 1'b1;
          state_d   = DONE;
        end
`endif
        else begin
          state_d = MUL_YY;
        end
      end
      MUL_YY: if (mul_vld) begin ld_t0 = 1'b1; state_d = MUL_XX; end
      MUL_XX: if (mul_vld) begin ld_t1 = 1'b1; state_d = ADD_A;  end
      ADD_A:  if (add_vld) begin ld_t1 = 1'b1; state_d = MUL_X;  end
      MUL_X:  if (mul_vld) begin ld_t1 = 1'b1; state_d = ADD_B;  end
      ADD_B:  if (add_vld) begin ld_t1 = 1'b1; state_d = CMP;    end
      CMP: begin
        set_curve = (t0_q == t1_q);
        state_d   = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (in_arith && !ld_t0 && !ld_t1 && wait_cnt == CW'(TIMEOUT)) begin
      set_tmo = 1'b1;
      state_d = DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      t0_q      <= '0;
      t1_q      <= '0;
      wait_cnt  <= '0;
      on_curve  <= 1'b0;
      err_range <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      if (accept) begin
        x_q       <= Px;
        y_q       <= Py;
        on_curve  <= 1'b0;
        err_range <= 1'b0;
        err_tmo   <= 1'b0;
      end
      if (ld_t0)     t0_q      <= mul_res;
      if (ld_t1)     t1_q      <= is_add ? add_res : mul_res;
      if (set_curve) on_curve  <= 1'b1;
      if (set_range) err_range <= 1'b1;
      if (set_tmo)   err_tmo   <= 1'b1;
      wait_cnt <= (in_arith && state_d == state) ? wait_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_ec_point_check.sv
// Bench for ec_point_check: directed scenarios plus random points scored against a curve-equation model.
module tb_ec_point_check;
  import ec_point_check_pkg::*;

  localparam int TMO    = 1;
  localparam int WINDOW = 40;
  // Each arithmetic step lasts its unit latency plus one; RANGE before, CMP after.
  localparam int FULL_LAT = 2 + 3 * (MUL_LAT + 1) + 2 * (ADD_LAT + 1) + 1;
  localparam logic [255:0] P   = `PRIME;
  localparam logic [255:0] GXV = `GX;
  localparam logic [255:0] GYV = `GY;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, start_t = 1'b0;
  logic [255:0] Px = '0, Py = '0, Px_t = '0, Py_t = '0;
  logic         busy, done, on_curve, err_range, err_tmo;
  logic         busy_t, done_t, on_curve_t, err_range_t, err_tmo_t;
  int           n_checks = 0, n_fail = 0, mul_starts = 0;

  always #5 clk = ~clk;

  ec_point_check dut (
    .clk(clk), .rst(rst), .start(start), .Px(Px), .Py(Py), .busy(busy), .done(done),
    .on_curve(on_curve), .err_range(err_range), .err_tmo(err_tmo)
  );

  // Timeout shorter than the multiplier latency: every multiply valid arrives too late.
  ec_point_check #(.TIMEOUT(TMO)) dut_tmo (
    .clk(clk), .rst(rst), .start(start_t), .Px(Px_t), .Py(Py_t), .busy(busy_t), .done(done_t),
    .on_curve(on_curve_t), .err_range(err_range_t), .err_tmo(err_tmo_t)
  );

  always @(negedge clk) if (dut.mul_start === 1'b1) mul_starts <= mul_starts + 1;

  function automatic void model(input logic [255:0] x, input logic [255:0] y,
                                output bit exp_rng, output bit exp_oc, output int exp_lat);
    logic [511:0] p, lhs, rhs;
    p       = {256'b0, P};
    exp_rng = (x >= P) || (y >= P);
    exp_oc  = 1'b0;
    exp_lat = 2;
    if (exp_rng) return;
`ifdef ECCHK_INFINITY_EN
    if (x == 256'd0 && y == 256'd0) begin
      exp_oc = 1'b1;
      return;
    end
`endif
    lhs     = ({256'b0, y} * {256'b0, y}) % p;
    rhs     = ({256'b0, x} * {256'b0, x}) % p;
    rhs     = (rhs * {256'b0, x}) % p;
    rhs     = (rhs + ({256'b0, `COEF_A} * {256'b0, x}) % p + {256'b0, `COEF_B}) % p;
    exp_oc  = (lhs == rhs);
    exp_lat = FULL_LAT;
  endfunction

  task automatic run_point(input logic [255:0] x, input logic [255:0] y, input int again_at,
                           input logic [255:0] y2, output int lat, output int ndone,
                           output logic oc, output logic er, output logic et, output logic busy1);
    @(negedge clk);
    Px = x; Py = y; start = 1'b1;
    lat = -1; ndone = 0; oc = 1'bx; er = 1'bx; et = 1'bx; busy1 = 1'b0;
    for (int cyc = 1; cyc <= WINDOW; cyc++) begin
      @(negedge clk);
      start = (cyc == again_at);
      if (cyc == again_at) Py = y2;
      if (cyc == 1) busy1 = busy;
      if (done === 1'b1) begin
        ndone++;
        if (lat < 0) begin
          lat = cyc; oc = on_curve; er = err_range; et = err_tmo;
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, on_curve, err_range, err_tmo} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000", {busy, done, on_curve, err_range, err_tmo});
    end
    n_checks++;
    if ({busy_t, done_t, on_curve_t, err_range_t, err_tmo_t} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_tmo: got %b expected 00000",
               {busy_t, done_t, on_curve_t, err_range_t, err_tmo_t});
    end
    rst = 1'b0;
  endtask

  task automatic test_generator();
    int lat, nd, m0; logic oc, er, et, b1;
    m0 = mul_starts;
    run_point(GXV, GYV, -1, '0, lat, nd, oc, er, et, b1);
    n_checks++;
    if (lat !== FULL_LAT) begin n_fail++; $display("FAIL gen_latency: got %0d expected %0d", lat, FULL_LAT); end
    n_checks++;
    if (nd !== 1) begin n_fail++; $display("FAIL gen_done_count: got %0d expected 1", nd); end
    n_checks++;
    if ({oc, er, et} !== 3'b100) begin n_fail++; $display("FAIL gen_flags: got %b expected 100", {oc, er, et}); end
    n_checks++;
    if (b1 !== 1'b1) begin n_fail++; $display("FAIL gen_busy: got %b expected 1", b1); end
    n_checks++;
    if (on_curve !== 1'b1) begin n_fail++; $display("FAIL gen_on_curve_held: got %b expected 1", on_curve); end
    n_checks++;
    if (mul_starts - m0 !== 3) begin
      n_fail++; $display("FAIL gen_mul_starts: got %0d expected 3", mul_starts - m0);
    end
  endtask

  task automatic test_off_curve();
    int lat, nd; logic oc, er, et, b1;
    run_point(GXV, GYV + 256'd1, -1, '0, lat, nd, oc, er, et, b1);
    n_checks++;
    if ({oc, er, et} !== 3'b000) begin n_fail++; $display("FAIL off_curve_flags: got %b expected 000", {oc, er, et}); end
    n_checks++;
    if (lat !== FULL_LAT) begin n_fail++; $display("FAIL off_curve_latency: got %0d expected %0d", lat, FULL_LAT); end
  endtask

  task automatic test_range();
    int lat, nd, m0; logic oc, er, et, b1;
    m0 = mul_starts;
    run_point(P, GYV, -1, '0, lat, nd, oc, er, et, b1);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL range_latency: got %0d expected 2", lat); end
    n_checks++;
    if ({oc, er, et} !== 3'b010) begin n_fail++; $display("FAIL range_flags: got %b expected 010", {oc, er, et}); end
    n_checks++;
    if (mul_starts != m0) begin n_fail++; $display("FAIL range_mul_start: got %0d starts expected 0", mul_starts - m0); end
  endtask

  task automatic test_back_to_back();
    int lat, nd; logic oc, er, et, b1;
    run_point(GXV, GYV, 3, GYV + 256'd1, lat, nd, oc, er, et, b1);
    n_checks++;
    if (nd !== 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 1", nd); end
    n_checks++;
    if ({oc, er, et} !== 3'b100) begin n_fail++; $display("FAIL b2b_flags: got %b expected 100", {oc, er, et}); end
    n_checks++;
    if (lat !== FULL_LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", lat, FULL_LAT); end
  endtask

  task automatic test_reset_mid_op();
    int lat, nd; logic oc, er, et, b1;
    @(negedge clk);
    Px = GXV; Py = GYV; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, on_curve, err_range, err_tmo} !== 5'b0) begin
      n_fail++;
      $display("FAIL midop_reset: got %b expected 00000", {busy, done, on_curve, err_range, err_tmo});
    end
    @(negedge clk);
    rst = 1'b0;
    run_point(GXV, GYV, -1, '0, lat, nd, oc, er, et, b1);
    n_checks++;
    if ({oc, er, et} !== 3'b100 || nd !== 1) begin
      n_fail++; $display("FAIL midop_restart: got flags %b dones %0d expected 100 and 1", {oc, er, et}, nd);
    end
  endtask

  task automatic test_infinity();
    int lat, nd, exp_lat; logic oc, er, et, b1; bit exp_rng, exp_oc;
    model('0, '0, exp_rng, exp_oc, exp_lat);
    run_point('0, '0, -1, '0, lat, nd, oc, er, et, b1);
    n_checks++;
    if (oc !== exp_oc || lat !== exp_lat) begin
      n_fail++; $display("FAIL infinity: got oc=%b lat=%0d expected oc=%b lat=%0d", oc, lat, exp_oc, exp_lat);
    end
  endtask

  task automatic test_random();
    int lat, nd, exp_lat; logic oc, er, et, b1; bit exp_rng, exp_oc;
    logic [255:0] x, y;
    for (int i = 0; i < 24; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      y = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      x[255] = 1'b0; y[255] = 1'b0;
      case ($urandom_range(0, 4))
        0: begin x = GXV; y = GYV; end
        1: begin x = GXV; y = P - GYV; end
        2: ;
        3: x = P + 256'($urandom_range(0, 900));
        default: y = P + 256'($urandom_range(0, 900));
      endcase
      model(x, y, exp_rng, exp_oc, exp_lat);
      run_point(x, y, -1, '0, lat, nd, oc, er, et, b1);
      n_checks++;
      if ({oc, er, et} !== {exp_oc, exp_rng, 1'b0} || lat !== exp_lat || nd !== 1) begin
        n_fail++;
        $display("FAIL random_%0d: got flags %b lat %0d dones %0d expected flags %b lat %0d dones 1",
                 i, {oc, er, et}, lat, nd, {exp_oc, exp_rng, 1'b0}, exp_lat);
      end
    end
  endtask

  task automatic test_timeout();
    int lat = -1, nd = 0; logic oc = 1'bx, er = 1'bx, et = 1'bx;
    @(negedge clk);
    Px_t = GXV; Py_t = GYV; start_t = 1'b1;
    for (int cyc = 1; cyc <= WINDOW; cyc++) begin
      @(negedge clk);
      start_t = 1'b0;
      if (done_t === 1'b1) begin
        nd++;
        if (lat < 0) begin lat = cyc; oc = on_curve_t; er = err_range_t; et = err_tmo_t; end
      end
    end
    n_checks++;
    if ({oc, er, et} !== 3'b001) begin n_fail++; $display("FAIL tmo_flags: got %b expected 001", {oc, er, et}); end
    n_checks++;
    if (nd !== 1) begin n_fail++; $display("FAIL tmo_done_count: got %0d expected 1", nd); end
    n_checks++;
    if (lat !== TMO + 3) begin n_fail++; $display("FAIL tmo_latency: got %0d expected %0d", lat, TMO + 3); end
  endtask

  initial begin
    test_reset();
    test_generator();
    test_off_curve();
    test_range();
    test_back_to_back();
    test_reset_mid_op();
    test_infinity();
    test_random();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
